// File: rtl/flap_ctrl.sv
// -----------------------------------------------------------------------------
// flap_ctrl
//
// Player-input and gravity timing stage for the flappy-bird LED game.
// Turns the raw, active-low, asynchronous flap pushbutton into a single-cycle
// `press` pulse. Generates the periodic `gravity` pulse that pulls the bird
// down. Also sequences the game:
//   IDLE   -> waiting for the first flap; nothing moves.
//   HANG   -> just flapped; gravity ticks are swallowed for HANG_TICKS ticks.
//   RUN    -> normal play; every tick becomes a `gravity` pulse.
//   FROZEN -> game lost; everything is silent until reset.
//
// Parameters
//   GRAV_PERIOD  clock cycles between gravity ticks (>= 2)
//   HANG_TICKS   gravity ticks suppressed after each flap (0 = no hang time)
//
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   key_n    in   raw pushbutton, active-low, asynchronous to clk
//   lose     in   level from the collision logic: the game is lost
//   press    out  one-cycle flap pulse (registered)
//   gravity  out  one-cycle fall pulse (registered)
//   running  out  high while in RUN or HANG (registered)
// -----------------------------------------------------------------------------
module flap_ctrl #(
  parameter int GRAV_PERIOD = 8,
  parameter int HANG_TICKS  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic lose,
  output logic press,
  output logic gravity,
  output logic running
);

  // Counter widths. The hang counter keeps at least one bit, so it stays
  // legal when HANG_TICKS is 0.
  localparam int TW = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;
  localparam int HW = (HANG_TICKS > 0) ? $clog2(HANG_TICKS + 1) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(GRAV_PERIOD - 1);
  localparam logic [HW-1:0] H_LOAD = HW'(HANG_TICKS);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HANG   = 2'd2,
    FROZEN = 2'd3
  } state_t;

  // State entered after any accepted flap. Without hang time there is
  // nothing to wait for, so the bird goes straight to RUN.
  localparam state_t FLAP_DEST = (HANG_TICKS == 0) ? RUN : HANG;

  state_t          state;
  logic            s1;
  logic            s2;
  logic            kd;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   hcnt;

  logic            flap;
  logic            active;
  logic            tick;
  logic [TW-1:0]   tcnt_next;

  // --------------------------------------------------------------------------
  // Button synchronizer and falling-edge detect.
  // s1/s2 form the two-flop synchronizer. kd is s2 delayed by one cycle.
  // A high-to-low transition of the synchronized button (button pushed) is a
  // flap. Holding the button keeps s2 and kd both low, so it gives only one
  // edge.
  // --------------------------------------------------------------------------
  // NOTE: reset here is synchronous and active-high, matching the rest of the
  // game logic, so it is tested inside the clocked block and not listed in
  // the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      kd <= 1'b1;
    end else begin
      // NOTE: clocked state uses non-blocking assignments. This way s2 and kd
      // both see the values from before this edge and form a real shift chain.
      s1 <= key_n;
      s2 <= s1;
      kd <= s2;
    end
  end

  assign flap = ~s2 & kd;

  // The tick counter only advances while the game is alive. A tick is the
  // last count of each period.
  assign active    = (state == RUN) || (state == HANG);
  assign tick      = active && (tcnt == T_LAST);
  assign tcnt_next = (tcnt == T_LAST) ? '0 : (tcnt + T_ONE);

  // --------------------------------------------------------------------------
  // Game FSM with registered outputs.
  // Priority inside each live state is lose > flap > tick. A flap therefore
  // swallows a coinciding tick, so press and gravity can never both be high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tcnt    <= '0;
      hcnt    <= '0;
      press   <= 1'b0;
      gravity <= 1'b0;
      running <= 1'b0;
    end else begin
      // Pulses default low. Each branch below raises at most one of them.
      press   <= 1'b0;
      gravity <= 1'b0;

      case (state)
        IDLE: begin
          tcnt    <= '0;
          running <= 1'b0;
          // lose is not looked at here: a stale collision level must not
          // stop the game from starting.
          if (flap) begin
            press   <= 1'b1;
            running <= 1'b1;
            hcnt    <= H_LOAD;
            state   <= FLAP_DEST;
          end
        end

        RUN: begin
          if (lose) begin
            running <= 1'b0;
            tcnt    <= '0;
            state   <= FROZEN;
          end else if (flap) begin
            // Restart the period so the hang time is measured from this flap.
            press <= 1'b1;
            tcnt  <= '0;
            hcnt  <= H_LOAD;
            state <= FLAP_DEST;
          end else begin
            tcnt <= tcnt_next;
            if (tick) begin
              gravity <= 1'b1;
            end
          end
        end

        HANG: begin
          if (lose) begin
            running <= 1'b0;
            tcnt    <= '0;
            state   <= FROZEN;
          end else if (flap) begin
            press <= 1'b1;
            tcnt  <= '0;
            hcnt  <= H_LOAD;
            state <= FLAP_DEST;
          end else begin
            tcnt <= tcnt_next;
            // Ticks are counted down but never turned into gravity. The tick
            // that consumes the last hang count hands over to RUN, and gravity
            // starts on the following tick.
            if (tick) begin
              if (hcnt <= H_ONE) begin
                hcnt  <= '0;
                state <= RUN;
              end else begin
                hcnt <= hcnt - H_ONE;
              end
            end
          end
        end

        FROZEN: begin
          // Terminal until reset. Counters hold their values and key edges
          // are ignored.
          running <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          tcnt    <= '0;
          hcnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flap_ctrl
//
// Directed, self-checking bench for flap_ctrl.
//   dut   : GRAV_PERIOD=8, HANG_TICKS=2 (main game timing)
//   dut_b : GRAV_PERIOD=4, HANG_TICKS=0 (no hang time)
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, so each sample shows what the DUT registered on that edge. `n`
// numbers the edges since the current phase began. Expected pulse positions
// are hand-derived edge numbers.
// -----------------------------------------------------------------------------
module tb_flap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, key_n, lose;
  logic press, gravity, running;

  logic reset_b, key_n_b, lose_b;
  logic press_b, gravity_b, running_b;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  flap_ctrl #(.GRAV_PERIOD(8), .HANG_TICKS(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .lose    (lose),
    .press   (press),
    .gravity (gravity),
    .running (running)
  );

  flap_ctrl #(.GRAV_PERIOD(4), .HANG_TICKS(0)) dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .key_n   (key_n_b),
    .lose    (lose_b),
    .press   (press_b),
    .gravity (gravity_b),
    .running (running_b)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, n, obs, exp);
    end
  endtask

  // Advance one rising edge and move to the sampling point just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic expect_a(input string tag, input logic p, input logic g, input logic r);
    check({tag, ".press"},   press,   p);
    check({tag, ".gravity"}, gravity, g);
    check({tag, ".running"}, running, r);
  endtask

  task automatic expect_b(input string tag, input logic p, input logic g, input logic r);
    check({tag, ".press"},   press_b,   p);
    check({tag, ".gravity"}, gravity_b, g);
    check({tag, ".running"}, running_b, r);
  endtask

  initial begin
    reset   = 1'b1;
    key_n   = 1'b0;
    lose    = 1'b0;
    reset_b = 1'b1;
    key_n_b = 1'b1;
    lose_b  = 1'b0;

    // Reset held for 2 cycles with the button pushed: everything stays 0.
    for (int i = 0; i < 2; i++) begin
      cyc();
      expect_a("reset", 1'b0, 1'b0, 1'b0);
    end

    // Start and hold, then hang and fall. The button stays pushed: s1 falls
    // at edge 1 and s2 at edge 2, so press is registered at edge E=3. Ticks
    // come at edges 11 and 19 (hang), and gravity at 27, 35, 43.
    n     = 0;
    reset = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cyc();
      expect_a("start_hang", n == 3, (n == 27) || (n == 35) || (n == 43), n >= 3);
    end

    // Release the button (edges 46..48) so a new edge can form.
    key_n = 1'b0;
    key_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_a("release", 1'b0, 1'b0, 1'b1);
    end

    // Push again. key_n is sampled low at edge 49 and s2 falls at 50, so the
    // flap is seen while tcnt==7. It is registered at edge 51 and swallows
    // that tick. The next gravity comes 24 cycles later, at edge 75.
    key_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      expect_a("reflap", n == 51, n == 75, 1'b1);
    end

    // One cycle of lose while in RUN (edge 81) freezes everything.
    lose = 1'b1;
    cyc();
    expect_a("lose", 1'b0, 1'b0, 1'b0);
    lose = 1'b0;

    // Toggle the button 3 times while frozen: no pulses may follow.
    key_n = 1'b1;
    for (int i = 82; i <= 110; i++) begin
      if (i == 85) key_n = 1'b0;
      if (i == 88) key_n = 1'b1;
      cyc();
      expect_a("frozen", 1'b0, 1'b0, 1'b0);
    end

    // Reset returns the block to IDLE.
    reset = 1'b1;
    cyc();
    expect_a("mid_reset", 1'b0, 1'b0, 1'b0);

    // Restart the game with lose held high while in IDLE, where it must be
    // ignored. The button is sampled low at edge 112 and press comes at 114.
    // Gravity first appears at 114+24 = 138.
    reset = 1'b0;
    lose  = 1'b1;
    key_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      expect_a("idle_lose", 1'b0, 1'b0, 1'b0);
    end
    lose = 1'b0;
    for (int i = 114; i <= 140; i++) begin
      cyc();
      expect_a("restart", n == 114, n == 138, 1'b1);
    end

    // A flap edge that lands on the same edge as lose (and as a tick, at
    // edge 146) must produce no press and no gravity.
    key_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_a("release2", 1'b0, 1'b0, 1'b1);
    end
    key_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      expect_a("pre_lose", 1'b0, 1'b0, 1'b1);
    end
    lose = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_a("lose_flap", 1'b0, 1'b0, 1'b0);
    end

    // Zero hang time, period 4. The flap goes straight to RUN with press at
    // edge 3, then gravity at 7, 11 and 15.
    n       = 0;
    reset_b = 1'b0;
    key_n_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      expect_b("zero_hang", n == 3, (n == 7) || (n == 11) || (n == 15), n >= 3);
    end

    // Reset in the middle of a game drops every output on the next edge.
    reset_b = 1'b1;
    cyc();
    expect_b("b_mid_reset", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flap_ctrl.md
# flap_ctrl

Player-input and gravity timing stage for the flappy-bird LED game. Conditions the raw active-low flap pushbutton into a single-cycle `press` pulse and generates the periodic `gravity` pulse. Both pulses feed every bird-column light cell directly downstream. Implements the game start, the post-flap hang time and the freeze on `lose`.

## Interface
- `GRAV_PERIOD`, default 8: clock cycles between gravity ticks; must be ≥ 2.
- `HANG_TICKS`, default 2: gravity ticks suppressed after each flap; 0 means no hang time.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `key_n`  in  1  raw pushbutton, active-low, asynchronous to `clk`.
- `lose`  in  1  level; game lost, from the collision logic.
- `press`  out  1  one-cycle flap pulse, registered.
- `gravity`  out  1  one-cycle fall pulse, registered.
- `running`  out  1  high in RUN or HANG, registered.

## Operation
- **Synchronizer and edge detect**
  - `key_n` passes through two flops `s1`, `s2`; `s2` is delayed once more into `kd`.
  - All three reset to 1 (button released).
  - A flap edge is `~s2 & kd`.
  - Holding the button yields exactly one edge; a release-then-press yields a new edge.
- **Tick counter**
  - `tcnt`, width `$clog2(GRAV_PERIOD)`, counts 0 to `GRAV_PERIOD-1` and wraps.
  - It counts only in RUN and HANG; it is held at 0 in IDLE and FROZEN.
  - `tick` = (`tcnt == GRAV_PERIOD-1`) in RUN or HANG.
- **Hang counter**
  - `hcnt`, width `$clog2(HANG_TICKS+1)` (minimum 1).
- **States:** IDLE, RUN, HANG, FROZEN. Reset enters IDLE.
- **IDLE**
  - A flap edge produces a `press` pulse and goes to HANG with `hcnt<=HANG_TICKS`, `tcnt<=0`.
  - If `HANG_TICKS==0`, the flap edge goes to RUN instead.
  - `lose` is ignored.
- **RUN**
  - A tick produces a `gravity` pulse.
  - A flap edge produces a `press` pulse, restarts `tcnt<=0`, loads `hcnt<=HANG_TICKS` and goes to HANG (or stays in RUN if `HANG_TICKS==0`).
- **HANG**
  - No `gravity` is produced.
  - On a tick, `hcnt` decrements; if `hcnt==1`, the block goes to RUN.
  - A flap edge reloads `hcnt` and `tcnt` exactly as in RUN and produces `press`.
- **FROZEN**
  - Entered from RUN or HANG when `lose` is high.
  - All outputs are 0, counters are held, and key edges are ignored.
  - Leaves only on `reset`.
- **Priorities for simultaneous events:** `reset` > `lose` > flap edge > tick.
  - A tick coinciding with a flap edge is discarded.
  - `press` and `gravity` are never high in the same cycle.
  - A flap edge coinciding with `lose` produces no `press`.
- `reset` mid-game drops all outputs and flops on the next edge and returns to IDLE.

## Timing
- Reset values:
  - `press`, `gravity`, `running` = 0.
  - `s1`, `s2`, `kd` = 1.
  - `tcnt`, `hcnt` = 0.
- Press latency:
  - `key_n` is low at sampling edge k; `s2` goes low at edge k+1.
  - The edge is detected in the cycle after k+1.
  - `press` is high for the single cycle after edge k+2.
- Hang-time timing:
  - Let edge E be the edge that registers `press`.
  - Ticks occur at edges E+n·`GRAV_PERIOD`.
  - HANG ends at E+`HANG_TICKS`·`GRAV_PERIOD`.
  - The first `gravity` is high after edge E+(`HANG_TICKS`+1)·`GRAV_PERIOD`.
- In steady RUN, `gravity` is high exactly 1 of every `GRAV_PERIOD` cycles.
- `running` rises on the edge that registers the first `press`.
- `running` falls on the edge at which `lose` is sampled high.
- Outputs freeze (go to 0) on the edge at which `lose` is sampled high; no further pulses follow.

## Test plan
- **Reset:** hold `reset` 2 cycles with `key_n=0` -> all outputs 0, state IDLE; no `press` while `reset` is high.
- **Start and hold:** release `reset`, hold `key_n=0` for 20 cycles -> exactly one `press`, in the cycle after the 3rd edge; `running=1` from then on.
- **Hang then fall** (P=8, H=2): after `press` at edge E, no `gravity` through E+16 -> `gravity` at E+24, E+32, E+40 (one cycle each).
- **Collision and re-flap:**
  - Flap edge detected exactly when `tcnt==7` in RUN -> `press=1`, `gravity=0` that cycle.
  - The next `gravity` comes 24 cycles later.
- **Lose:**
  - `lose=1` for one cycle in RUN, then `key_n` toggled 3 times -> `running=0`, `press=0` and `gravity=0` indefinitely.
  - `reset` returns the block to IDLE; the next flap restarts the game.
- **Zero hang** (`HANG_TICKS=0`, `GRAV_PERIOD=4`): start flap -> RUN immediately; `gravity` 4 cycles after `press`, then every 4 cycles.
